// File: rtl/ddl_event_merge_fsm.sv
// ============================================================================
// Module   : ddl_event_merge_fsm
// Merges per-partition DTC RAM event flags into one DDL event-send flag, with
// masking, laggard timeout, xoff gating and confirm/clear handshakes.
// Option   : DDL_EVENT_MERGE_STATS_EN builds the event/timeout counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddl_event_merge_fsm #(
    parameter int NPART = 2,
    parameter int TO_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             dcsclk,
    input  logic             reset,
    input  logic [NPART-1:0] part_ram_flag,
    input  logic [NPART-1:0] part_mask,
    input  logic [NPART-1:0] ddl_xoff,
    input  logic [NPART-1:0] read_confirm,
    input  logic [TO_W-1:0]  timeout_cfg,
    output logic             event_send,
    output logic [NPART-1:0] part_sel,
    output logic [NPART-1:0] part_clr,
    output logic             busy,
    output logic             timeout_seen,
    output logic [CNT_W-1:0] event_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_COLLECT   = 3'd1;
    localparam logic [2:0] S_XOFF_WAIT = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_CLEAR     = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [TO_W-1:0]  r_to_cnt;
    logic [NPART-1:0] r_part_sel;
    logic [NPART-1:0] r_conf;
    logic             r_event_send;
    logic             r_timeout_seen;

    logic [NPART-1:0] w_rdy;
    logic [NPART-1:0] w_conf_new;
    logic             w_timeout_hit;
    logic             w_close;
    logic             w_xoff_sel;

    assign w_rdy         = part_ram_flag & part_mask;
    assign w_conf_new    = read_confirm & r_part_sel;
    assign w_xoff_sel    = |(ddl_xoff & r_part_sel);
    assign w_timeout_hit = (timeout_cfg != '0) && (r_to_cnt == timeout_cfg - TO_W'(1));
    // An event closes once every enabled partition is ready or the laggard wait expires.
    assign w_close       = (w_rdy != '0) && ((w_rdy == part_mask) || w_timeout_hit);

    always_ff @(posedge dcsclk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rdy != '0) w_next_state = S_COLLECT;
            end
            S_COLLECT: begin
                if (w_rdy == '0)  w_next_state = S_IDLE;
                else if (w_close) w_next_state = S_XOFF_WAIT;
            end
            S_XOFF_WAIT: begin
                if (!w_xoff_sel) w_next_state = S_SEND;
            end
            S_SEND: begin
                // A final confirm completes the event even if xoff rises in the same cycle.
                if ((r_conf | w_conf_new) == r_part_sel) w_next_state = S_CLEAR;
            end
            S_CLEAR: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge dcsclk or posedge reset) begin
        if (reset) begin
            r_to_cnt       <= '0;
            r_part_sel     <= '0;
            r_conf         <= '0;
            r_event_send   <= 1'b0;
            r_timeout_seen <= 1'b0;
        end else begin
            if (r_state == S_COLLECT) begin
                if (r_to_cnt != '1) r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end

            if ((r_state == S_COLLECT) && w_close) r_part_sel <= w_rdy;

            if (r_state == S_SEND) r_conf <= r_conf | w_conf_new;
            else                   r_conf <= '0;

            r_event_send   <= (w_next_state == S_SEND) && !w_xoff_sel;
            r_timeout_seen <= (r_state == S_COLLECT) && w_close && (w_rdy != part_mask);
        end
    end

    always_comb begin
        busy         = (r_state != S_IDLE);
        part_clr     = (r_state == S_CLEAR) ? r_part_sel : '0;
        part_sel     = r_part_sel;
        event_send   = r_event_send;
        timeout_seen = r_timeout_seen;
    end

`ifdef DDL_EVENT_MERGE_STATS_EN
    logic [CNT_W-1:0] r_event_cnt;
    logic [CNT_W-1:0] r_timeout_cnt;

    always_ff @(posedge dcsclk or posedge reset) begin
        if (reset) begin
            r_event_cnt   <= '0;
            r_timeout_cnt <= '0;
        end else begin
            if (r_state == S_CLEAR) r_event_cnt <= r_event_cnt + CNT_W'(1);
            if ((r_state == S_COLLECT) && w_close && (w_rdy != part_mask))
                r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
        end
    end

    assign event_cnt   = r_event_cnt;
    assign timeout_cnt = r_timeout_cnt;
`else
    assign event_cnt   = {CNT_W{1'b0}};
    assign timeout_cnt = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddl_event_merge_fsm.sv
// ============================================================================
// Module   : tb_ddl_event_merge_fsm
// Directed bench for ddl_event_merge_fsm (NPART=2 main instance, NPART=8 wide).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddl_event_merge_fsm;

`ifdef DDL_EVENT_MERGE_STATS_EN
    localparam int c_STATS = 1;
`else
    localparam int c_STATS = 0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  flag, mask, xoff, rconf;
    logic [15:0] tcfg;
    logic        es, busy, tseen;
    logic [1:0]  sel, clr;
    logic [15:0] ecnt, tcnt;

    logic [7:0]  w8_flag, w8_mask, w8_xoff, w8_rconf;
    logic [3:0]  w8_tcfg;
    logic        w8_es, w8_busy, w8_tseen;
    logic [7:0]  w8_sel, w8_clr;
    logic [15:0] w8_ecnt, w8_tcnt;

    int n_checks = 0;
    int n_fail   = 0;

    ddl_event_merge_fsm #(.NPART(2), .TO_W(16), .CNT_W(16)) u_dut (
        .dcsclk(clk), .reset(rst), .part_ram_flag(flag), .part_mask(mask),
        .ddl_xoff(xoff), .read_confirm(rconf), .timeout_cfg(tcfg),
        .event_send(es), .part_sel(sel), .part_clr(clr), .busy(busy),
        .timeout_seen(tseen), .event_cnt(ecnt), .timeout_cnt(tcnt)
    );

    ddl_event_merge_fsm #(.NPART(8), .TO_W(4), .CNT_W(16)) u_dut_w8 (
        .dcsclk(clk), .reset(rst), .part_ram_flag(w8_flag), .part_mask(w8_mask),
        .ddl_xoff(w8_xoff), .read_confirm(w8_rconf), .timeout_cfg(w8_tcfg),
        .event_send(w8_es), .part_sel(w8_sel), .part_clr(w8_clr), .busy(w8_busy),
        .timeout_seen(w8_tseen), .event_cnt(w8_ecnt), .timeout_cnt(w8_tcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        flag = '0; mask = '0; xoff = '0; rconf = '0; tcfg = '0;
        w8_flag = '0; w8_mask = '0; w8_xoff = '0; w8_rconf = '0; w8_tcfg = '0;
        tick(2);
        check("rst_es", 32'(es), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sel", 32'(sel), 0);
        check("rst_clr", 32'(clr), 0);
        rst = 1'b0;
        tick(1);

        // Basic event: 3-cycle latency, two confirms, one-cycle clear
        mask = 2'b11; flag = 2'b11;
        tick(1);
        check("t1_busy", 32'(busy), 1);
        tick(1);
        check("t1_es_c2", 32'(es), 0);
        tick(1);
        check("t1_es_c3", 32'(es), 1);
        check("t1_sel", 32'(sel), 2'b11);
        rconf = 2'b01; tick(1); rconf = 2'b00;
        check("t1_no_clr_yet", 32'(clr), 0);
        rconf = 2'b10; tick(1); rconf = 2'b00;
        check("t1_clr", 32'(clr), 2'b11);
        check("t1_es_clear", 32'(es), 0);
        flag = 2'b00;
        tick(1);
        check("t1_clr_pulse", 32'(clr), 0);
        check("t1_idle", 32'(busy), 0);
        check("t1_ecnt", 32'(ecnt), 32'(c_STATS));

        // Laggard timeout
        tcfg = 16'd10; flag = 2'b01;
        tick(1);
        check("t2_busy", 32'(busy), 1);
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (tseen) begin
                n = i;
                break;
            end
        end
        check("t2_to_delay", 32'(n), 10);
        check("t2_sel", 32'(sel), 2'b01);
        check("t2_tcnt", 32'(tcnt), 32'(c_STATS));
        tick(1);
        check("t2_tseen_pulse", 32'(tseen), 0);
        check("t2_es", 32'(es), 1);
        rconf = 2'b01; tick(1); rconf = 2'b00;
        check("t2_clr", 32'(clr), 2'b01);
        flag = 2'b00; tcfg = '0;
        tick(1);
        check("t2_idle", 32'(busy), 0);

        // Xoff during SEND, confirm retention, confirm beats xoff
        flag = 2'b11;
        tick(3);
        check("t3_es_on", 32'(es), 1);
        xoff = 2'b10;
        for (int i = 0; i < 5; i++) begin
            rconf = (i == 1 || i == 3) ? 2'b01 : 2'b00;
            tick(1);
            check("t3_es_xoff", 32'(es), 0);
        end
        rconf = 2'b00; xoff = 2'b00;
        tick(1);
        check("t3_es_resume", 32'(es), 1);
        check("t3_still_send", 32'(clr), 0);
        rconf = 2'b10; xoff = 2'b10;
        tick(1);
        rconf = 2'b00; xoff = 2'b00;
        check("t3_clr_wins", 32'(clr), 2'b11);
        flag = 2'b00;
        tick(1);
        check("t3_ecnt", 32'(ecnt), 32'(3 * c_STATS));

        // Fully masked: never leaves IDLE
        mask = 2'b00; flag = 2'b11;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("t4_busy", 32'({busy, es}), 0);
        end

        // Asynchronous reset mid-SEND, then restart from the still-high flags
        mask = 2'b11;
        tick(3);
        check("t5_es_on", 32'(es), 1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_es", 32'(es), 0);
        check("t5_async_busy", 32'(busy), 0);
        check("t5_async_sel", 32'(sel), 0);
        check("t5_async_ecnt", 32'(ecnt), 0);
        #1 rst = 1'b0;
        tick(1);
        check("t5_recollect", 32'({busy, sel}), 3'b100);
        tick(2);
        check("t5_es_again", 32'(es), 1);
        rconf = 2'b11; tick(1); rconf = 2'b00;
        check("t5_clr", 32'(clr), 2'b11);
        flag = 2'b00;
        tick(1);
        check("t5_ecnt", 32'(ecnt), 32'(c_STATS));

        // Wide instance: no timeout, counter saturates, eighth flag completes
        w8_mask = 8'hff; w8_flag = 8'h7f; w8_tcfg = 4'd0;
        tick(40);
        check("t6_busy", 32'(w8_busy), 1);
        check("t6_wait", 32'({w8_es, w8_sel, w8_tseen}), 0);
        w8_flag = 8'hff;
        tick(2);
        check("t6_es", 32'(w8_es), 1);
        check("t6_sel", 32'(w8_sel), 8'hff);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
